// File: rtl/b_pkg.sv
// ---- b_pkg : shared keys, width and word type for the B transform pair ----
`default_nettype none
package b_pkg;

  localparam int unsigned B_W = 32;

  typedef logic [B_W-1:0] b_word_t;

  // Single source for the forward (B) and inverse (b_inv) key defaults.
  localparam b_word_t B_D0 = 32'h0012_E480;
  localparam b_word_t B_D1 = 32'h00C2_5EA1;
  localparam b_word_t B_D2 = 32'h10C0_1284;

endpackage
`default_nettype wire

// File: rtl/b_pipe_stage.sv
// ---- b_pipe_stage : one data register plus valid bit with load enable ----
`default_nettype none
module b_pipe_stage
  import b_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    load_i,
  input  logic    valid_i,
  input  b_word_t data_i,
  output logic    valid_o,
  output b_word_t data_o
);

  logic    valid_q, valid_d;
  b_word_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/b_inv.sv
// ---- b_inv : 3-stage pipelined inverse of B, x = ((y ^ K2) - K1) ^ K0 ----
// ---- Optional output-transfer counter when B_INV_COUNT_EN is defined.  ----
`default_nettype none
module b_inv
  import b_pkg::*;
#(
  parameter b_word_t K0 = B_D0,
  parameter b_word_t K1 = B_D1,
  parameter b_word_t K2 = B_D2
) (
  input  logic    clock,
  input  logic    reset,
  input  b_word_t in_data,
  input  logic    in_valid,
  output logic    in_ready,
  output b_word_t out,
  output logic    out_valid,
  input  logic    out_ready
`ifdef B_INV_COUNT_EN
  ,
  output logic [B_W-1:0] count
`endif
);

  localparam int unsigned c_STAGES = 3;

  b_word_t               w_stage_in [c_STAGES];
  b_word_t               w_stage_q  [c_STAGES];
  logic [c_STAGES-1:0]   w_valid_in;
  logic [c_STAGES-1:0]   w_valid_q;
  logic [c_STAGES-1:0]   w_adv;

  // A stage may load when it is empty or its content moves on this cycle.
  assign w_adv[2] = !w_valid_q[2] | out_ready;
  assign w_adv[1] = !w_valid_q[1] | w_adv[2];
  assign w_adv[0] = !w_valid_q[0] | w_adv[1];
  assign in_ready = w_adv[0];

  assign w_stage_in[0] = in_data ^ K2;
  assign w_stage_in[1] = w_stage_q[0] - K1;
  assign w_stage_in[2] = w_stage_q[1] ^ K0;

  assign w_valid_in = {w_valid_q[1], w_valid_q[0], in_valid};

  generate
    for (genvar gi = 0; gi < int'(c_STAGES); gi++) begin : g_stage
      b_pipe_stage u_stage (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (w_adv[gi]),
        .valid_i (w_valid_in[gi]),
        .data_i  (w_stage_in[gi]),
        .valid_o (w_valid_q[gi]),
        .data_o  (w_stage_q[gi])
      );
    end
  endgenerate

  assign out       = w_stage_q[2];
  assign out_valid = w_valid_q[2];

`ifdef B_INV_COUNT_EN
  logic [B_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_b_inv.sv
// ---- tb_b_inv : directed self-checking bench for b_inv ----
`default_nettype none
module tb_b_inv;

  localparam logic [31:0] D0 = 32'h0012_E480;
  localparam logic [31:0] D1 = 32'h00C2_5EA1;
  localparam logic [31:0] D2 = 32'h10C0_1284;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
`ifdef B_INV_COUNT_EN
  logic [31:0] count;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_in    = 0;
  int          n_out   = 0;
  logic [31:0] tb_exp  = '0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_count = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = '0;

  b_inv dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef B_INV_COUNT_EN
    ,
    .count     (count)
`endif
  );

  always #5 clock = ~clock;

  // Forward B transform; expected plaintexts come from encoding them here.
  function automatic logic [31:0] enc(input logic [31:0] x);
    return ((x ^ D0) + D1) ^ D2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: order, value, hold-while-stalled, and counter tracking.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      exp_count  = '0;
      prev_stall = 1'b0;
    end else begin
`ifdef B_INV_COUNT_EN
      check_eq("count", count, exp_count);
`endif
      if (prev_stall) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_data", out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_out", 32'(out_valid), 32'd0);
        else check_eq("stream", out, exp_q.pop_front());
        n_out++;
        exp_count = exp_count + 1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(tb_exp);
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
  end

  task automatic one_word(input logic [31:0] y, input logic [31:0] x, input string tag);
    tick();
    in_data = y; tb_exp = x; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clock); check_eq({tag, "_v1"}, 32'(out_valid), 32'd0);
    tick();
    @(negedge clock); check_eq({tag, "_v2"}, 32'(out_valid), 32'd0);
    tick();
    @(negedge clock); check_eq({tag, "_v3"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, out, x);
    tick();
    @(negedge clock); check_eq({tag, "_v4"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] x;
    int          acc;
    int          base;
    int          sent;
    logic        need_new;

    reset = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_out", out, 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    check_eq("rel_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clock);
    check_eq("idle_valid", 32'(out_valid), 32'd0);

    // Decodes to zero, then the borrow/wrap case.
    one_word(32'h1015_51A5, 32'h0000_0000, "zero");
    one_word(32'h10C0_1284, 32'hFF2F_45DF, "wrap");

    // Back-to-back streaming at full rate.
    for (int i = 0; i < 1000; i++) begin
      tick();
      x = $urandom;
      in_data = enc(x); tb_exp = x; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clock);
      check_eq("stream_in_ready", 32'(in_ready), 32'd1);
    end
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check_eq("stream_count", 32'(n_out), 32'(n_in));
    check_eq("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: three accepts then in_ready must fall.
    acc = 0; need_new = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      out_ready = 1'b0;
      if (need_new) begin
        x = $urandom;
        in_data = enc(x); tb_exp = x;
      end
      in_valid = 1'b1;
      @(negedge clock);
      need_new = in_ready;
      if (in_ready) acc++;
    end
    check_eq("stall_accepts", 32'(acc), 32'd3);
    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    check_eq("stall_out_valid", 32'(out_valid), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    check_eq("stall_drained", 32'(exp_q.size()), 32'd0);
    check_eq("stall_count", 32'(n_out), 32'(n_in));

    // Mid-stream reset with two words in flight.
    out_ready = 1'b0;
    x = 32'hDEAD_BEEF;
    in_data = enc(x); tb_exp = x; in_valid = 1'b1;
    tick();
    x = 32'h1234_5678;
    in_data = enc(x); tb_exp = x;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_out", out, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    x = 32'hCAFE_F00D;
    one_word(enc(x), x, "post_rst");
    repeat (3) tick();
    check_eq("post_rst_drained", 32'(exp_q.size()), 32'd0);

`ifdef B_INV_COUNT_EN
    // Counter: five output transfers under random stalls after a fresh reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    base = n_out; sent = 0; need_new = 1'b1;
    for (int c = 0; c < 300 && (n_out - base) < 5; c++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      if (need_new) begin
        x = $urandom;
        in_data = enc(x); tb_exp = x;
      end
      in_valid = (sent < 5);
      @(negedge clock);
      need_new = in_valid && in_ready;
      if (in_valid && in_ready) sent++;
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_eq("count_transfers", 32'(n_out - base), 32'd5);
    check_eq("count_final", count, 32'd5);
`else
    base = 0; sent = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
